// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and FSM state encoding for the uart
//                transmit buffer (byte width, bytes per word, states).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_byte_w         = 8;
    localparam int c_bytes_per_word = 4;
    localparam int c_word_w         = c_byte_w * c_bytes_per_word;

    // Transmit sequencer states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync_fifo
//  Description : Single-clock show-ahead FIFO. dout presents the head entry
//                whenever the FIFO is not empty; pushes while full and pops
//                while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int               c_aw       = $clog2(DEPTH);
    localparam logic [c_aw:0]    c_full_cnt = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == c_full_cnt);
    assign empty     = (r_count == '0);
    assign level     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates reads
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_buffer
//  Description : Transmit front end for the uart core. Queues 32-bit words,
//                unpacks each MSB-first into bytes and hands them to the uart
//                over the tx_ena / tx_data / tx_busy handshake, with sticky
//                overflow and handshake-timeout flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [c_word_w-1:0]    wr_data,
    output logic                   wr_full,
    output logic [$clog2(DEPTH):0] wr_level,
    input  logic                   clr_err,
    output logic                   overflow,
    output logic                   ack_err,
    input  logic                   tx_busy,
    output logic                   tx_ena,
    output logic [c_byte_w-1:0]    tx_data,
    output logic                   idle
);

    localparam int                   c_tmo_w     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [c_tmo_w-1:0]   c_tmo_last  = c_tmo_w'(ACK_TIMEOUT - 1);
    localparam int                   c_cnt_w     = $clog2(c_bytes_per_word);
    localparam logic [c_cnt_w-1:0]   c_last_byte = c_cnt_w'(c_bytes_per_word - 1);

    tx_state_t             r_state;
    logic [c_word_w-1:0]   r_shift;
    logic [c_cnt_w-1:0]    r_byte_cnt;
    logic [c_tmo_w-1:0]    r_tmo;
    logic                  r_tx_ena;
    logic [c_byte_w-1:0]   r_tx_data;
    logic                  r_overflow;
    logic                  r_ack_err;

    logic [c_word_w-1:0]   w_fifo_dout;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic                  w_ack_to;
    logic                  w_adv;
    logic                  w_last_byte;
    logic                  w_pop;

    uart_sync_fifo #(
        .WIDTH (c_word_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (w_pop),
        .din   (wr_data),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .level (wr_level)
    );

    // The uart never acknowledged: give up on this byte and move on
    assign w_ack_to    = (r_state == ST_WAIT_ACK) && !tx_busy && (r_tmo == c_tmo_last);
    // Current byte is finished, either normally or by timeout
    assign w_adv       = w_ack_to || ((r_state == ST_WAIT_DONE) && !tx_busy);
    assign w_last_byte = (r_byte_cnt == c_last_byte);
    // Head word is taken from idle, or chained straight after a word's last byte
    assign w_pop       = !w_fifo_empty && ((r_state == ST_IDLE) || (w_adv && w_last_byte));

    assign wr_full  = w_fifo_full;
    assign overflow = r_overflow;
    assign ack_err  = r_ack_err;
    assign tx_ena   = r_tx_ena;
    assign tx_data  = r_tx_data;
    // Built from registered state only, so it settles with the clock edge
    assign idle     = (r_state == ST_IDLE) && w_fifo_empty;

    // Byte sequencer: loads words, issues one tx_ena pulse per byte, tracks the ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_tmo      <= '0;
            r_tx_ena   <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_ena <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_shift    <= w_fifo_dout;
                        r_byte_cnt <= '0;
                        r_tx_data  <= w_fifo_dout[c_word_w-1 -: c_byte_w];
                        r_tx_ena   <= 1'b1;
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_tmo   <= '0;
                    r_state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_tmo != c_tmo_last) begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    r_state <= ST_WAIT_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_adv) begin
                if (w_last_byte) begin
                    if (!w_fifo_empty) begin
                        r_shift    <= w_fifo_dout;
                        r_byte_cnt <= '0;
                        r_tx_data  <= w_fifo_dout[c_word_w-1 -: c_byte_w];
                        r_tx_ena   <= 1'b1;
                        r_state    <= ST_SEND;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end else begin
                    r_shift    <= {r_shift[c_word_w-c_byte_w-1:0], {c_byte_w{1'b0}}};
                    r_byte_cnt <= r_byte_cnt + 1'b1;
                    r_tx_data  <= r_shift[c_word_w-c_byte_w-1 -: c_byte_w];
                    r_tx_ena   <= 1'b1;
                    r_state    <= ST_SEND;
                end
            end
        end
    end

    // Sticky error flags; a new error event in the same cycle beats clr_err
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_ack_err  <= 1'b0;
        end else begin
            if (wr_en && w_fifo_full) r_overflow <= 1'b1;
            else if (clr_err)         r_overflow <= 1'b0;

            if (w_ack_to)             r_ack_err  <= 1'b1;
            else if (clr_err)         r_ack_err  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Transmit-side front end for the `uart` core.
- Accepts 32-bit words from the memory-mapped write path and queues them in a word FIFO.
- Unpacks each word into four bytes, MSB first, and hands them one at a time to the uart through its `tx_ena` / `tx_data` / `tx_busy` handshake.
- The CPU can post up to DEPTH words without polling `tx_busy`.

Parameters:
- DEPTH, 8: FIFO depth in 32-bit words; power of two, minimum 2.
- ACK_TIMEOUT, 16: cycles to wait for `tx_busy` to rise after a `tx_ena` pulse before declaring a handshake error.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  push `wr_data` into the FIFO this cycle.
- wr_data  in  32  word to transmit; byte [31:24] is sent first.
- wr_full  out  1  FIFO holds DEPTH words.
- wr_level  out  $clog2(DEPTH)+1  number of words queued, excluding the word being sent.
- clr_err  in  1  clears `overflow` and `ack_err`.
- overflow  out  1  sticky; set by a write while `wr_full`=1.
- ack_err  out  1  sticky; set when `tx_busy` fails to rise within ACK_TIMEOUT.
- tx_busy  in  1  from uart; high while a byte is being serialized.
- tx_ena  out  1  to uart; one-cycle pulse requesting transmission.
- tx_data  out  8  to uart; byte to send, held stable from the `tx_ena` pulse until `tx_busy` falls.
- idle  out  1  FIFO empty and FSM in IDLE.

Behaviour:
- Reset values:
  - `tx_ena`=0, `tx_data`=8'h00, `wr_full`=0, `wr_level`=0, `overflow`=0, `ack_err`=0, `idle`=1.
  - FIFO pointers = 0; FSM = IDLE.
  - Reset mid-transfer discards the FIFO contents and the partially sent word immediately.
- FIFO:
  - Push when `wr_en`=1 and `wr_full`=0.
  - Write with `wr_full`=1 is dropped and sets `overflow`, even if a pop happens the same cycle.
  - Push and pop in the same cycle keep the level unchanged.
  - Pointers wrap modulo DEPTH.
  - `wr_full` and `wr_level` are registered and reflect the state after the current edge.
- FSM states: IDLE, SEND, WAIT_ACK, WAIT_DONE.
  - IDLE: if FIFO non-empty, pop the head word into a 32-bit shift register, byte count=0, go to SEND. Otherwise stay.
  - SEND (exactly 1 cycle): `tx_ena`=1, `tx_data`=shift[31:24]. Go to WAIT_ACK with the timeout counter cleared.
  - WAIT_ACK: if `tx_busy`=1, go to WAIT_DONE. If the counter reaches ACK_TIMEOUT-1, set `ack_err` and treat the byte as sent (go to the byte-advance step). Otherwise increment the counter.
  - WAIT_DONE: when `tx_busy`=0, do the byte-advance step.
  - Byte-advance step: shift left by 8 and increment byte count.
    - If count was 3: go to IDLE, or directly pop the next word and go to SEND if the FIFO is non-empty.
    - Otherwise go to SEND.
- Latency: `wr_en` sampled at edge E0 into an empty, idle block → `tx_ena`=1 during the cycle after E1 (2 edges).
- Back-to-back bytes are separated by at least 1 cycle after `tx_busy` falls.
- `tx_ena` is never asserted while `tx_busy`=1.
- `tx_data` holds its value outside SEND; it changes only on entry to SEND.
- `clr_err` in the same cycle as a new error event: the set wins.
- `idle` = (FSM==IDLE) && (level==0); registered.

Decomposition:
- Shared header `uart_pkg.vh`: FSM state localparams (2-bit encoding), BYTES_PER_WORD=4, and the byte width of 8.
- One sub-module, `uart_sync_fifo`, parameterised by WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty, level.
  - Show-ahead read (`dout` valid whenever not empty); asynchronous active-high reset.
- The FSM, shift register and timeout counter live in `uart_tx_buffer`.

Test Plan:
- Single word: write 32'h12345678, with a uart model raising `tx_busy` 1 cycle after `tx_ena` for 20 cycles → `tx_ena` pulses carry 8'h12, 8'h34, 8'h56, 8'h78 in order; `idle` returns to 1; `ack_err`=0.
- Fill and overflow: with `tx_busy` held 1, write 10 words (DEPTH=8) → after the first word is popped the FIFO holds 8 words, `wr_full`=1, the 10th write is dropped, `overflow`=1; `clr_err` clears it.
- Ordering: stream words 32'hA0A1A2A3 … 32'hA7A8A9AA back-to-back → 32 bytes emitted in exact FIFO/MSB-first order with no `tx_ena` pulse while `tx_busy`=1.
- Timeout: `tx_busy` tied 0, write 32'hDEADBEEF → `ack_err` set 16 cycles after the first pulse; all four bytes still issued, each ACK_TIMEOUT apart.
- Reset mid-operation: assert `reset` during the third byte of a word with 3 more words queued → outputs immediately take reset values, `wr_level`=0; no further `tx_ena` after release.
- Simultaneous push/pop: write exactly on the edge where IDLE pops the last word → `wr_level` stays 1 and the new word is sent next.
